axis_wrr_sched: RTL
===================

# axis_wrr_sched

Weighted round-robin frame scheduler for the 4-input AXI stream arbitrating mux. It watches per-input frame requests and per-input frame-end acknowledges, and drives the mux select signals (`grant`, `grant_valid`, `grant_encoded`). Each input gets up to `cfg_weight[i]` consecutive frames per round before the grant rotates. Grants are frame-granular: a grant is held from frame start until the granted input's `tlast` beat is accepted.

## Interface
- `S_COUNT`, 4: number of requesting inputs (≥2).
- `WEIGHT_WIDTH`, 4: width of each per-input weight/credit field.
- `CL_S_COUNT`, `$clog2(S_COUNT)`: encoded grant width (derived, not overridden).
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `request`  in  S_COUNT  per-input frame request (= `s_axis_tvalid[i]`).
- `acknowledge`  in  S_COUNT  per-input frame-end pulse (= `tvalid & tready & tlast` of input i).
- `cfg_weight`  in  S_COUNT*WEIGHT_WIDTH  frames per round; field i at `[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]`; 0 = input disabled.
- `grant`  out  S_COUNT  one-hot grant, registered.
- `grant_valid`  out  1  grant active, registered.
- `grant_encoded`  out  CL_S_COUNT  index of granted input, registered.

## Operation
- Registers:
  - `state` (IDLE/GRANT).
  - `ptr` (CL_S_COUNT): current round-robin position.
  - `credit` (WEIGHT_WIDTH): frames left for `ptr`.
  - Output registers.
- IDLE, continue rule: if `request[ptr] && cfg_weight[ptr]!=0 && credit!=0`, then candidate = `ptr`; `credit` unchanged.
- IDLE, search rule (otherwise):
  - Search indices `ptr+1, ptr+2, … ptr` (mod S_COUNT, `ptr` itself last) for the first i with `request[i] && cfg_weight[i]!=0`.
  - On a hit: candidate = i, `ptr<=i`, `credit<=cfg_weight[i]`.
  - This search abandons any leftover credit of the old `ptr`.
- IDLE, on candidate c: `grant<=1<<c`, `grant_encoded<=c`, `grant_valid<=1`; go to GRANT.
- IDLE, no candidate: all registers hold.
- GRANT: hold all outputs until `acknowledge[grant_encoded]`. Then:
  - `grant<=0`, `grant_valid<=0`.
  - `grant_encoded` holds its last value.
  - `credit<=credit-1`, saturating at 0.
  - Go to IDLE.
- `acknowledge` bits of non-granted inputs are ignored, as is any `acknowledge` in IDLE.
- `request` deassertion during GRANT is ignored; the grant persists until acknowledge, because the frame is in progress.
- `cfg_weight` is sampled only in IDLE. Changing it during GRANT does not alter loaded `credit`. A weight of 0 on `ptr` forces a search on the next IDLE.
- Reset values: `grant=0`, `grant_valid=0`, `grant_encoded=0`, `state=IDLE`, `ptr=S_COUNT-1`, `credit=0`. As a result, the first search starts at input 0.

## Timing
- Grant latency: a request sampled in IDLE at edge N gives the grant visible after edge N (1 cycle).
- Acknowledge sampled at edge M: `grant_valid` is 0 after edge M; the earliest re-grant is after edge M+1. This leaves one bubble cycle between frames, which is intentional.
- Single-beat frames need at least 2 cycles per frame.
- Simultaneous `acknowledge` and new requests at edge M: the requests are evaluated in IDLE at M+1 with the decremented credit.
- Asynchronous reset mid-GRANT: outputs clear immediately, without waiting for a clock edge. Arbitration restarts from input 0 after release. The downstream mux is reset together with this block.

## Structure
- Shared package/include:
  - State encodings `STATE_IDLE=1'b0`, `STATE_GRANT=1'b1`.
  - The CL_S_COUNT width derivation.
- One sub-module: `priority_encoder`. It takes the eligible mask rotated right by `ptr+1` and returns the first set index plus a valid bit. The parent un-rotates the result (mod S_COUNT).
- Credit counter, state register and output registers stay in the top.

## Test plan
All scenarios use S_COUNT=4, WEIGHT_WIDTH=4.
- **Reset/idle:** hold `rst`, then release with `request=0`. Required: `grant=0`, `grant_valid=0`, `grant_encoded=0` for 10 cycles. Then set `request=4'b0001`, weights all 1. Required: `grant=4'b0001`, `grant_encoded=0` one cycle later.
- **Weighting:** weights {p0=3, p1=1, p2=1, p3=1}, `request=4'b1111` constant, acknowledge 2 cycles after each grant. Required grant order: 0,0,0,1,2,3,0,0,0,1.
- **Disabled input:** `cfg_weight[p2]=0`, `request=4'b0100`. Required: `grant_valid` stays 0 for 20 cycles. Then set `request=4'b0110`. Required: only input 1 is ever granted.
- **Credit abandon:** p0 weight 3. p0 requests one frame, then drops; p1 requests. Required: grant p0 once, then p1. When p0 re-requests, p0 gets three consecutive frames.
- **Handshake rules:** during a grant on p1, drop `request[1]` and pulse `acknowledge[3]`. Required: the grant stays `4'b0010`. Then `acknowledge[1]`. Required: `grant_valid` is 0 the next cycle, and the next grant follows one cycle after that.
- **Reset mid-frame:** assert `rst` asynchronously during a grant on p2. Required: `grant_valid` falls before the next clock edge. After release with `request=4'b1001`: required grant `4'b0001`.

Source files
------------

// File: rtl/axis_wrr_sched_pkg.sv
// Shared definitions for the weighted round-robin frame scheduler.
//   state_e   : FSM encoding (IDLE waits for a candidate, GRANT waits for frame end)
//   cl_width  : encoded-index width helper, never narrower than 1 bit
package axis_wrr_sched_pkg;

   typedef enum logic {
      STATE_IDLE  = 1'b0,
      STATE_GRANT = 1'b1
   } state_e;

   function automatic int cl_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axis_wrr_sched_priority_encoder.sv
// Lowest-index-first priority encoder.
//   mask_i  : request mask, bit 0 has highest priority
//   idx_o   : index of the lowest set bit (0 when none)
//   valid_o : at least one bit of mask_i is set
module priority_encoder
   import axis_wrr_sched_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int IW    = cl_width(WIDTH)
) (
   input  logic [WIDTH-1:0] mask_i,
   output logic [IW-1:0]    idx_o,
   output logic             valid_o
);

   // Scan high to low so the lowest set bit is written last and wins.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o   = IW'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_wrr_sched.sv
// Weighted round-robin frame scheduler driving the select lines of a
// frame-granular AXI stream mux.
//   clk, rst      : clock, asynchronous active-high reset
//   request       : per-input frame request (tvalid)
//   acknowledge   : per-input frame end (tvalid & tready & tlast)
//   cfg_weight    : per-input frames per round, 0 disables the input
//   grant         : registered one-hot grant
//   grant_valid   : registered grant-active flag
//   grant_encoded : registered index of the granted input (holds after release)
module axis_wrr_sched
   import axis_wrr_sched_pkg::*;
#(
   parameter  int S_COUNT      = 4,
   parameter  int WEIGHT_WIDTH = 4,
   localparam int CL_S_COUNT   = cl_width(S_COUNT)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [S_COUNT-1:0]              request,
   input  logic [S_COUNT-1:0]              acknowledge,
   input  logic [S_COUNT*WEIGHT_WIDTH-1:0] cfg_weight,
   output logic [S_COUNT-1:0]              grant,
   output logic                            grant_valid,
   output logic [CL_S_COUNT-1:0]           grant_encoded
);

   state_e                  state_q, state_d;
   logic [CL_S_COUNT-1:0]   ptr_q, ptr_d;
   logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
   logic [S_COUNT-1:0]      grant_q, grant_d;
   logic                    gv_q, gv_d;
   logic [CL_S_COUNT-1:0]   enc_q, enc_d;

   logic [WEIGHT_WIDTH-1:0] wts [S_COUNT];
   logic [S_COUNT-1:0]      elig, elig_rot;
   logic [CL_S_COUNT-1:0]   rot_src;
   logic [CL_S_COUNT-1:0]   pe_idx, hit_idx;
   logic                    pe_valid;
   logic [CL_S_COUNT-1:0]   cand;
   logic                    cand_ok;

   always_comb begin
      rot_src = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         wts[i]  = cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         elig[i] = request[i] && (wts[i] != '0);
      end
      // Rotate so that ptr+1 lands at bit 0 and ptr itself is searched last.
      for (int j = 0; j < S_COUNT; j++) begin
         rot_src     = CL_S_COUNT'((j + int'(ptr_q) + 1) % S_COUNT);
         elig_rot[j] = elig[rot_src];
      end
   end

   priority_encoder #(.WIDTH(S_COUNT)) u_pe (
      .mask_i  (elig_rot),
      .idx_o   (pe_idx),
      .valid_o (pe_valid)
   );

   assign hit_idx = CL_S_COUNT'((int'(pe_idx) + int'(ptr_q) + 1) % S_COUNT);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= STATE_IDLE;
         ptr_q    <= CL_S_COUNT'(S_COUNT - 1);
         credit_q <= '0;
         grant_q  <= '0;
         gv_q     <= 1'b0;
         enc_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
         grant_q  <= grant_d;
         gv_q     <= gv_d;
         enc_q    <= enc_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      credit_d = credit_q;
      grant_d  = grant_q;
      gv_d     = gv_q;
      enc_d    = enc_q;
      cand     = '0;
      cand_ok  = 1'b0;
      case (state_q)
         STATE_IDLE: begin
            if (request[ptr_q] && (wts[ptr_q] != '0) && (credit_q != '0)) begin
               cand    = ptr_q;
               cand_ok = 1'b1;
            end else if (pe_valid) begin
               // Moving on forfeits whatever credit the old ptr still had.
               cand     = hit_idx;
               cand_ok  = 1'b1;
               ptr_d    = hit_idx;
               credit_d = wts[hit_idx];
            end
            if (cand_ok) begin
               grant_d = S_COUNT'(1) << cand;
               enc_d   = cand;
               gv_d    = 1'b1;
               state_d = STATE_GRANT;
            end
         end
         STATE_GRANT: begin
            // Only the granted input's frame end releases the grant.
            if (acknowledge[enc_q]) begin
               grant_d  = '0;
               gv_d     = 1'b0;
               credit_d = (credit_q == '0) ? '0 : credit_q - WEIGHT_WIDTH'(1);
               state_d  = STATE_IDLE;
            end
         end
         default: state_d = STATE_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      grant         = grant_q;
      grant_valid   = gv_q;
      grant_encoded = enc_q;
   end

endmodule
